// File: rtl/shift_pkg.sv
// Shared types for the PISO serializer: shift direction and controller state.
package shift_pkg;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module shift_bit_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in/serial-out shift register: loads a word, then streams it one bit
// per clock, MSB-first (left) or LSB-first (right), with o_valid per bit.
module shift_register_piso
  import shift_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ld_data,
  input  logic                 i_sht_lr,
  input  logic [BUS_WIDTH-1:0] i_reg_data,
  output logic                 o_busy,
  output logic                 o_shift,
  output logic                 o_valid
);

  localparam int unsigned CW = $clog2(BUS_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(BUS_WIDTH - 1);

  shift_state_t         state;
  shift_dir_t           dir;
  logic [BUS_WIDTH-1:0] data_q;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;

  assign cnt_load = (state == ST_IDLE) && i_ld_data;
  assign cnt_dec  = (state == ST_SHIFT);

  shift_bit_counter #(
    .WIDTH (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAST_IDX),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // data_q keeps the presented bit at its edge; the next bit sits one position inward.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      dir     <= SHIFT_LEFT;
      data_q  <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_shift <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (i_ld_data) begin
        state   <= ST_SHIFT;
        dir     <= shift_dir_t'(i_sht_lr);
        data_q  <= i_reg_data;
        o_busy  <= 1'b1;
        o_valid <= 1'b1;
        o_shift <= i_sht_lr ? i_reg_data[0] : i_reg_data[BUS_WIDTH-1];
      end
    end else begin
      if (cnt_zero) begin
        state   <= ST_IDLE;
        data_q  <= '0;
        o_busy  <= 1'b0;
        o_valid <= 1'b0;
        o_shift <= 1'b0;
      end else if (dir == SHIFT_LEFT) begin
        o_shift <= data_q[BUS_WIDTH-2];
        data_q  <= {data_q[BUS_WIDTH-2:0], 1'b0};
      end else begin
        o_shift <= data_q[1];
        data_q  <= {1'b0, data_q[BUS_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_shift_register_piso.sv
// Directed bench for shift_register_piso: bit order, framing, ignored loads and reset.
module tb_shift_register_piso;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         i_ld_data;
  logic         i_sht_lr;
  logic [W-1:0] i_reg_data;
  logic         o_busy;
  logic         o_shift;
  logic         o_valid;

  int unsigned checks;
  int unsigned failures;

  shift_register_piso #(
    .BUS_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ld_data  (i_ld_data),
    .i_sht_lr   (i_sht_lr),
    .i_reg_data (i_reg_data),
    .o_busy     (o_busy),
    .o_shift    (o_shift),
    .o_valid    (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  W'(o_busy),  '0);
    check({tag, "_valid"}, W'(o_valid), '0);
    check({tag, "_shift"}, W'(o_shift), '0);
  endtask

  // Called at a negedge: present a load for the next rising edge, return after it.
  task automatic load_word(input logic [W-1:0] word, input logic right);
    i_ld_data  = 1'b1;
    i_reg_data = word;
    i_sht_lr   = right;
    @(negedge clk);
    i_ld_data  = 1'b0;
  endtask

  // Receive one full word; modes: 1 = toggle inputs mid-stream, 2 = load while busy,
  // 3 = load held from the final bit cycle through the following edge.
  task automatic collect(input string tag, input logic [W-1:0] exp, input logic right,
                         input int unsigned mode, input logic [W-1:0] next_word);
    logic [W-1:0] rx;
    logic         exp_bit;
    int unsigned  bad_bits;
    rx = '0;
    bad_bits = 0;
    for (int unsigned i = 0; i < W; i++) begin
      exp_bit = right ? exp[i] : exp[W-1-i];
      if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_shift !== exp_bit) bad_bits++;
      if (i == 0) check({tag, "_first_bit"}, W'(o_shift), W'(exp_bit));
      rx = right ? {o_shift, rx[W-1:1]} : {rx[W-2:0], o_shift};
      if (mode == 1) begin
        i_reg_data = $urandom;
        i_sht_lr   = ~i_sht_lr;
      end
      if (mode == 2 && (i == 3 || i == 17)) begin
        i_ld_data  = 1'b1;
        i_reg_data = ~exp;
        i_sht_lr   = ~right;
      end else if (mode == 2) begin
        i_ld_data = 1'b0;
      end
      if (mode == 3 && i == W-1) begin
        i_ld_data  = 1'b1;
        i_reg_data = next_word;
        i_sht_lr   = right;
      end
      @(negedge clk);
    end
    check({tag, "_stream_bits"}, W'(bad_bits), '0);
    check({tag, "_rx"}, rx, exp);
    check_idle({tag, "_end"});
    if (mode != 3) i_ld_data = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    i_ld_data  = 1'b1;
    i_sht_lr   = 1'b0;
    i_reg_data = 32'hFFFF_FFFF;

    // Reset held with loads asserted
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("reset_hold");
    end
    rst       = 1'b0;
    i_ld_data = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Left, alternating pattern
    load_word(32'hAAAA_AAAA, 1'b0);
    collect("left_aaaa", 32'hAAAA_AAAA, 1'b0, 0, '0);

    // Right, single one in LSB
    load_word(32'h0000_0001, 1'b1);
    collect("right_0001", 32'h0000_0001, 1'b1, 0, '0);

    // Asymmetric words to pin the bit ordering
    load_word(32'h1234_5678, 1'b0);
    collect("left_1234", 32'h1234_5678, 1'b0, 0, '0);
    load_word(32'h8000_0000, 1'b1);
    collect("right_8000", 32'h8000_0000, 1'b1, 0, '0);

    // Random words, both directions, with and without input churn
    w = $urandom;
    load_word(w, 1'b0);
    collect("rand_left", w, 1'b0, 0, '0);
    w = $urandom;
    load_word(w, 1'b1);
    collect("rand_right", w, 1'b1, 0, '0);
    w = $urandom;
    load_word(w, 1'b0);
    collect("churn_left", w, 1'b0, 1, '0);
    w = $urandom;
    load_word(w, 1'b1);
    collect("churn_right", w, 1'b1, 1, '0);

    // Load while busy is ignored
    load_word(32'hC3A5_0F96, 1'b0);
    collect("busy_load", 32'hC3A5_0F96, 1'b0, 2, '0);

    // Load at the final edge ignored; held one more cycle it starts a new word
    load_word(32'h0F0F_1234, 1'b1);
    collect("end_load", 32'h0F0F_1234, 1'b1, 3, 32'hDEAD_BEEF);
    @(negedge clk);
    i_ld_data = 1'b0;
    collect("after_end_load", 32'hDEAD_BEEF, 1'b1, 0, '0);

    // Reset mid-word at bit 10, then a fresh word
    load_word(32'h5A5A_F00F, 1'b0);
    for (int unsigned i = 0; i < 10; i++) @(negedge clk);
    check("pre_rst_valid", W'(o_valid), W'(1'b1));
    check("pre_rst_bit10", W'(o_shift), W'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_mid_reset");
    load_word(32'h8421_0F7E, 1'b1);
    collect("post_rst_word", 32'h8421_0F7E, 1'b1, 0, '0);
    load_word(32'h8421_0F7E, 1'b0);
    collect("post_rst_left", 32'h8421_0F7E, 1'b0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
